// File: rtl/memory_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// memory_access_unit
//
// MEM-stage data-memory access controller. It takes one load or store from the
// EX/MEM pipeline register and turns it into a single req/ack bus transaction.
// Store data is replicated into byte lanes with matching byte enables. Load data
// is selected from the returned word and then sign- or zero-extended. stall_o
// is held high until the access completes, so the upstream pipeline enables
// can be gated with it.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses. A trapped access goes straight to DONE with no bus request,
// misaligned_o is raised for as long as DONE lasts, and ReadData_o is cleared.
// If the macro is undefined, the low address bits are ignored for the alignment
// check and misaligned_o is tied low.
//
// Parameters
//   DATA_WIDTH   bus data/address width (only 32 is supported)
//   ADDR_WIDTH   register-file index width of the pipeline this unit sits in
//
// Ports
//   clk, rst_n     clock (posedge) and asynchronous active-low reset
//   MemWrite_i     store request (has priority over a load)
//   ResultSrc_i    2'b01 marks a load
//   MemoryOp_i     funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (others as W)
//   ALUResult_i    byte address
//   WriteData_i    right-aligned store data
//   pipe_en_i      EX/MEM register advances at the next edge
//   mem_req_o      bus request (only while BUSY)
//   mem_we_o       bus write strobe
//   mem_addr_o     word-aligned bus address
//   mem_be_o       byte enables
//   mem_wdata_o    lane-aligned store data
//   mem_ack_i      one-cycle completion strobe; mem_rdata_i is valid with it
//   mem_rdata_i    read word
//   ReadData_o     extended load result, registered
//   stall_o        pipeline must hold (combinational)
//   misaligned_o   misaligned access trapped (MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module memory_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemWrite_i,
  input  logic [1:0]            ResultSrc_i,
  input  logic [2:0]            MemoryOp_i,
  input  logic [DATA_WIDTH-1:0] ALUResult_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  input  logic                  pipe_en_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  stall_o,
  output logic                  misaligned_o
);

  // The lane logic below is written for a 32-bit bus only.
  if (DATA_WIDTH != 32 || ADDR_WIDTH < 1) begin : g_bad_cfg
    $error("memory_access_unit: DATA_WIDTH must be 32 and ADDR_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  state_t                state;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] read_q;
  logic                  mis_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic       is_store;
  logic       is_load;
  logic       access;
  logic [1:0] a;
  size_t      size;
  logic       trap;

  assign is_store = MemWrite_i;
  assign is_load  = ~MemWrite_i & (ResultSrc_i == 2'b01);
  assign access   = is_store | is_load;
  assign a        = ALUResult_i[1:0];

  // funct3[1:0] alone selects the size; funct3[2] only picks zero-extension.
  // Codes 011, 110 and 111 fall into the word case.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    size = SZ_WORD;
    case (MemoryOp_i[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = ((size == SZ_HALF) & a[0]) | ((size == SZ_WORD) & (a != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus side: combinational from the EX/MEM inputs, which stay stable while
  // stall_o is high, so they are stable for the whole BUSY phase.
  // ---------------------------------------------------------------------------
  assign mem_req_o  = req_q;
  assign mem_we_o   = is_store;
  assign mem_addr_o = {ALUResult_i[DATA_WIDTH-1:2], 2'b00};

  always_comb begin
    mem_be_o    = 4'b1111;
    mem_wdata_o = WriteData_i;
    if (is_store) begin
      case (size)
        SZ_BYTE: begin
          mem_be_o    = 4'b0001 << a;
          mem_wdata_o = {4{WriteData_i[7:0]}};
        end
        SZ_HALF: begin
          // Without the trap, a[0] is ignored and the half sits in lane pair a[1].
          mem_be_o    = 4'b0011 << {a[1], 1'b0};
          mem_wdata_o = {2{WriteData_i[15:0]}};
        end
        default: begin
          mem_be_o    = 4'b1111;
          mem_wdata_o = WriteData_i;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension from the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  sign_ext;
  logic [DATA_WIDTH-1:0] load_ext;

  assign sign_ext = ~MemoryOp_i[2];
  assign half_sel = a[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    byte_sel = mem_rdata_i[7:0];
    case (a)
      2'd0: byte_sel = mem_rdata_i[7:0];
      2'd1: byte_sel = mem_rdata_i[15:8];
      2'd2: byte_sel = mem_rdata_i[23:16];
      2'd3: byte_sel = mem_rdata_i[31:24];
      default: byte_sel = mem_rdata_i[7:0];
    endcase
  end

  always_comb begin
    load_ext = mem_rdata_i;
    case (size)
      SZ_BYTE: load_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered request, load result and trap flag.
  // req_q mirrors "state == BUSY". Because it is a flop on the asynchronous
  // reset, the bus request drops as soon as rst_n falls and the in-flight
  // transaction is abandoned.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, whatever order the statements are in.
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      read_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (trap) begin
              state  <= DONE;
              read_q <= '0;
              mis_q  <= 1'b1;
            end else begin
              state <= BUSY;
              req_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state <= DONE;
            req_q <= 1'b0;
            if (is_load) begin
              read_q <= load_ext;
            end
          end
        end
        DONE: begin
          // Wait here until the pipeline takes the result. The access is not
          // issued again, and an ack that arrives in this state is ignored.
          if (pipe_en_i) begin
            state <= IDLE;
            mis_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          mis_q <= 1'b0;
        end
      endcase
    end
  end

  assign ReadData_o = read_q;
  // The stall rises in the IDLE cycle that sees the request, before any flop
  // has changed, so the EX/MEM register never advances past an open access.
  assign stall_o    = ((state == IDLE) & access) | (state == BUSY);

`ifdef MISALIGN_TRAP_EN
  assign misaligned_o = mis_q;
`else
  logic unused_mis;
  assign unused_mis   = mis_q;
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
`timescale 1ns/1ps
// Self-checking bench for memory_access_unit. Each transaction is described
// once (op, address, data, ack delay). A transaction-level model works out the
// expected lanes, store data and load result with plain arithmetic, and the
// expected cycle-by-cycle stall/req pattern follows from the protocol timing.
// The bench compares all outputs on every negedge, and then checks a few
// hand-computed literals.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite_i;
  logic [1:0]  ResultSrc_i;
  logic [2:0]  MemoryOp_i;
  logic [31:0] ALUResult_i;
  logic [31:0] WriteData_i;
  logic        pipe_en_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        misaligned_o;

  always #5 clk = ~clk;

  memory_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemWrite_i   (MemWrite_i),
    .ResultSrc_i  (ResultSrc_i),
    .MemoryOp_i   (MemoryOp_i),
    .ALUResult_i  (ALUResult_i),
    .WriteData_i  (WriteData_i),
    .pipe_en_i    (pipe_en_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .ReadData_o   (ReadData_o),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output values for the current cycle
  logic        exp_stall, exp_req, exp_mis, exp_we;
  logic [31:0] exp_read, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  // Values observed on the bus during a transaction, used for the literal checks
  int          stall_seen, req_seen;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int size_of(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Lowest byte lane touched: the address offset rounded down to the size.
  function automatic int lane_of(input logic [2:0] op, input logic [31:0] addr);
    int sz = size_of(op);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] op, input logic [31:0] addr);
    int sz = size_of(op);
    if (!we || sz == 4) return 4'hF;
    return 4'(((sz == 1) ? 1 : 3) << lane_of(op, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (size_of(op))
      1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int          sz = size_of(op);
    logic [31:0] v;
    if (sz == 4) return rdata;
    v = rdata >> (8 * lane_of(op, addr));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!op[2] && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = v & 32'hFFFF;
      if (!op[2] && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // This is the single compare point. It samples at negedge, checks against the
  // exp_* values, and returns #1 after the next posedge, when inputs may change.
  task automatic cycle_check(input string tag);
    @(negedge clk);
    check($sformatf("%s stall_o", tag), 32'(stall_o), 32'(exp_stall));
    check($sformatf("%s mem_req_o", tag), 32'(mem_req_o), 32'(exp_req));
    check($sformatf("%s ReadData_o", tag), ReadData_o, exp_read);
    check($sformatf("%s misaligned_o", tag), 32'(misaligned_o), 32'(exp_mis));
    if (exp_req) begin
      check($sformatf("%s mem_we_o", tag), 32'(mem_we_o), 32'(exp_we));
      check($sformatf("%s mem_addr_o", tag), mem_addr_o, exp_addr);
      check($sformatf("%s mem_be_o", tag), 32'(mem_be_o), 32'(exp_be));
      if (exp_we) check($sformatf("%s mem_wdata_o", tag), mem_wdata_o, exp_wdata);
    end
    if (stall_o === 1'b1) stall_seen++;
    if (mem_req_o === 1'b1) begin
      req_seen++;
      last_addr  = mem_addr_o;
      last_be    = mem_be_o;
      last_wdata = mem_wdata_o;
    end
    @(posedge clk);
    #1;
  endtask

  // One complete access: issue, BUSY until the ack in BUSY cycle ack_at, DONE held
  // for 'hold' cycles without pipe_en_i (with an optional stray ack), release, idle.
  task automatic run_access(input string tag, input logic we, input logic [1:0] rs,
                            input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata, input int hold,
                            input bit stray_ack);
    bit is_load;
    bit trap;
    is_load = !we && (rs == 2'b01);
    trap    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (size_of(op) == 2 && addr[0]) || (size_of(op) == 4 && addr[1:0] != 2'b00);
`endif
    MemWrite_i  = we;
    ResultSrc_i = rs;
    MemoryOp_i  = op;
    ALUResult_i = addr;
    WriteData_i = wd;
    pipe_en_i   = 1'b0;
    mem_ack_i   = 1'b0;
    exp_we      = we;
    exp_addr    = addr & ~32'h3;
    exp_be      = m_be(we, op, addr);
    exp_wdata   = m_wdata(op, wd);
    stall_seen  = 0;
    req_seen    = 0;

    exp_stall = 1'b1;
    exp_req   = 1'b0;
    cycle_check($sformatf("%s issue", tag));
    if (trap) begin
      exp_mis   = 1'b1;
      exp_read  = '0;
      exp_stall = 1'b0;
    end else begin
      for (int i = 1; i <= ack_at; i++) begin
        exp_req   = 1'b1;
        exp_stall = 1'b1;
        if (i == ack_at) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdata;
        end
        cycle_check($sformatf("%s busy%0d", tag, i));
      end
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h5A5A_5A5A;
      exp_req     = 1'b0;
      exp_stall   = 1'b0;
      if (is_load) exp_read = m_load(op, addr, rdata);
    end
    for (int h = 0; h < hold; h++) begin
      if (stray_ack && h == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1357_9BDF;
      end
      cycle_check($sformatf("%s done%0d", tag, h));
      mem_ack_i = 1'b0;
    end
    pipe_en_i = 1'b1;
    cycle_check($sformatf("%s release", tag));
    MemWrite_i  = 1'b0;
    ResultSrc_i = 2'b00;
    pipe_en_i   = 1'b0;
    exp_mis     = 1'b0;
    cycle_check($sformatf("%s idle", tag));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    MemWrite_i  = 1'b0;
    ResultSrc_i = 2'b00;
    MemoryOp_i  = 3'b000;
    ALUResult_i = '0;
    WriteData_i = '0;
    pipe_en_i   = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_we = 1'b0;
    exp_read  = '0;   exp_addr = '0;  exp_wdata = '0;  exp_be = 4'h0;
    last_addr = '0;   last_wdata = '0; last_be = 4'h0;
    stall_seen = 0;   req_seen = 0;

    repeat (2) @(posedge clk);
    #1;
    cycle_check("reset");
    rst_n = 1'b1;
    cycle_check("post reset");

    // 1. SW 0xDEADBEEF @0x100, ack in the third BUSY cycle
    run_access("sw", 1'b1, 2'b00, 3'b010, 32'h100, 32'hDEAD_BEEF, 3, 32'h0, 1, 1'b0);
    check("sw stall cycles", 32'(stall_seen), 32'd4);
    check("sw req cycles", 32'(req_seen), 32'd3);
    check("sw addr", last_addr, 32'h100);
    check("sw be", 32'(last_be), 32'hF);
    check("sw wdata", last_wdata, 32'hDEAD_BEEF);

    // 2. SB 0xA5 @0x103
    run_access("sb", 1'b1, 2'b00, 3'b000, 32'h103, 32'h0000_00A5, 1, 32'h0, 0, 1'b0);
    check("sb be", 32'(last_be), 32'h8);
    check("sb wdata", last_wdata, 32'hA5A5_A5A5);

    // 3. LB / LBU @0x102
    run_access("lb", 1'b0, 2'b01, 3'b000, 32'h102, 32'h0, 2, 32'h0080_0000, 0, 1'b0);
    check("lb result", ReadData_o, 32'hFFFF_FF80);
    run_access("lbu", 1'b0, 2'b01, 3'b100, 32'h102, 32'h0, 1, 32'h0080_0000, 0, 1'b0);
    check("lbu result", ReadData_o, 32'h0000_0080);

    // 4. LH @0x102 at minimum latency, DONE held two cycles with a stray ack
    run_access("lh", 1'b0, 2'b01, 3'b001, 32'h102, 32'h0, 1, 32'h8001_1234, 2, 1'b1);
    check("lh result", ReadData_o, 32'hFFFF_8001);
    check("lh req cycles", 32'(req_seen), 32'd1);
    check("lh stall cycles", 32'(stall_seen), 32'd2);

    // Halfword store, zero-extended half load, undefined funct3, store-over-load priority
    run_access("sh", 1'b1, 2'b00, 3'b001, 32'h102, 32'hBEEF_1234, 1, 32'h0, 0, 1'b0);
    check("sh be", 32'(last_be), 32'hC);
    check("sh wdata", last_wdata, 32'h1234_1234);
    run_access("lhu", 1'b0, 2'b01, 3'b101, 32'h100, 32'h0, 1, 32'h1234_F00D, 0, 1'b0);
    check("lhu result", ReadData_o, 32'h0000_F00D);
    run_access("lw op011", 1'b0, 2'b01, 3'b011, 32'h104, 32'h0, 2, 32'h89AB_CDEF, 0, 1'b0);
    check("op011 result", ReadData_o, 32'h89AB_CDEF);
    run_access("st+ld", 1'b1, 2'b01, 3'b000, 32'h101, 32'h0000_0077, 1, 32'hFFFF_FFFF, 0, 1'b0);
    check("st+ld keeps read", ReadData_o, 32'h89AB_CDEF);
    check("st+ld be", 32'(last_be), 32'h2);

    // Ack outside BUSY is ignored
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    cycle_check("idle ack");
    mem_ack_i = 1'b0;
    cycle_check("idle after ack");

    // 6. LW @0x101
    run_access("lw mis", 1'b0, 2'b01, 3'b010, 32'h101, 32'h0, 1, 32'hCAFE_F00D, 1, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("lw mis req cycles", 32'(req_seen), 32'd0);
    check("lw mis result", ReadData_o, 32'h0);
`else
    check("lw mis addr", last_addr, 32'h100);
    check("lw mis result", ReadData_o, 32'hCAFE_F00D);
`endif

    // Load that leaves ReadData_o nonzero before the reset test
    run_access("lw pre", 1'b0, 2'b01, 3'b010, 32'h200, 32'h0, 1, 32'h0BAD_CAFE, 0, 1'b0);

    // 5. Reset while BUSY
    MemWrite_i  = 1'b0;
    ResultSrc_i = 2'b01;
    MemoryOp_i  = 3'b010;
    ALUResult_i = 32'h300;
    exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF;
    exp_stall = 1'b1; exp_req = 1'b0;
    cycle_check("rst issue");
    exp_req = 1'b1;
    cycle_check("rst busy");
    #2;
    rst_n       = 1'b0;
    ResultSrc_i = 2'b00;
    #1;
    check("rst async mem_req_o", 32'(mem_req_o), 32'd0);
    check("rst async stall_o", 32'(stall_o), 32'd0);
    check("rst async ReadData_o", ReadData_o, 32'h0);
    exp_req = 1'b0; exp_stall = 1'b0; exp_read = '0;
    cycle_check("rst held");
    rst_n = 1'b1;
    cycle_check("rst released");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
